// File: rtl/network_interface.sv
`default_nettype none
// ============================================================================
// Module   : network_interface
// Brief    : Credit-based host-to-router NIC: one-entry TX hold, RX FIFO with
//            credit return, sticky error flags and wrapping flit counters.
// Revision : 1.0
// ============================================================================
module network_interface #(
    parameter logic [3:0] XCOORD     = 4'd0,
    parameter logic [3:0] YCOORD     = 4'd0,
    parameter int         TX_CREDITS = 4,
    parameter int         RX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,
    input  logic [7:0]  host_tx_dest,
    input  logic [7:0]  host_tx_payload,
    output logic [15:0] tx_data,
    output logic        tx_enable,
    input  logic        tx_credit,
    input  logic [15:0] rx_data,
    input  logic        rx_enable,
    output logic        rx_credit,
    output logic        host_rx_valid,
    input  logic        host_rx_ready,
    output logic [15:0] host_rx_data,
    output logic        err_overflow,
    output logic        err_credit,
    output logic        err_misroute,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam int AW = $clog2(RX_DEPTH);

    localparam logic [CW-1:0] c_max_credit = CW'(TX_CREDITS);
    localparam logic [CW-1:0] c_credit_one = CW'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);
    localparam logic [AW:0]   c_fill_one   = (AW+1)'(1);
    localparam logic [AW:0]   c_rx_depth   = (AW+1)'(RX_DEPTH);
    localparam logic [7:0]    c_local_addr = {XCOORD, YCOORD};

    // ---------------- TX path ----------------
    logic [15:0]   r_hold;
    logic          r_hold_valid;
    logic [CW-1:0] r_credit;
    logic          r_tx_enable;
    logic [15:0]   r_tx_data;
    logic [15:0]   r_tx_count;
    logic          r_err_credit;

    logic w_send_now;
    logic w_tx_accept;

    assign w_send_now    = r_hold_valid && (r_credit != '0);
    assign host_tx_ready = !r_hold_valid || w_send_now;
    assign w_tx_accept   = host_tx_valid && host_tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_credit     <= c_max_credit;
            r_tx_enable  <= 1'b0;
            r_tx_data    <= '0;
            r_tx_count   <= '0;
            r_err_credit <= 1'b0;
        end else begin
            r_tx_enable <= w_send_now;
            if (w_send_now) begin
                r_tx_data  <= r_hold;
                r_tx_count <= r_tx_count + 16'd1;
            end

            // A new flit can replace the one leaving in the same cycle.
            if (w_tx_accept) begin
                r_hold       <= {host_tx_payload, host_tx_dest};
                r_hold_valid <= 1'b1;
            end else if (w_send_now) begin
                r_hold_valid <= 1'b0;
            end

            case ({w_send_now, tx_credit})
                2'b10: r_credit <= r_credit - c_credit_one;
                2'b01: begin
                    if (r_credit == c_max_credit) begin
                        r_err_credit <= 1'b1;
                    end else begin
                        r_credit <= r_credit + c_credit_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic [15:0]   r_rx_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_rx_credit;
    logic [15:0]   r_rx_count;
    logic          r_err_overflow;
    logic          r_err_misroute;

    logic w_rx_pop;
    logic w_rx_full;
    logic w_rx_push;

    assign host_rx_valid = (r_fill != '0);
    assign host_rx_data  = r_rx_mem[r_rd_ptr];
    assign w_rx_pop      = host_rx_valid && host_rx_ready;
    // A pop in the same cycle frees a slot for the incoming flit.
    assign w_rx_full     = (r_fill == c_rx_depth) && !w_rx_pop;
    assign w_rx_push     = rx_enable && !w_rx_full;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fill         <= '0;
            r_rx_credit    <= 1'b0;
            r_rx_count     <= '0;
            r_err_overflow <= 1'b0;
            r_err_misroute <= 1'b0;
        end else begin
            r_rx_credit <= w_rx_pop;
            if (w_rx_push) begin
                r_wr_ptr   <= r_wr_ptr + c_ptr_one;
                r_rx_count <= r_rx_count + 16'd1;
                if (rx_data[7:0] != c_local_addr) begin
                    r_err_misroute <= 1'b1;
                end
            end
            if (rx_enable && w_rx_full) begin
                r_err_overflow <= 1'b1;
            end
            if (w_rx_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_fill <= r_fill + c_fill_one;
                2'b01:   r_fill <= r_fill - c_fill_one;
                default: ;
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_enable    = r_tx_enable;
    assign rx_credit    = r_rx_credit;
    assign err_overflow = r_err_overflow;
    assign err_credit   = r_err_credit;
    assign err_misroute = r_err_misroute;
    assign tx_count     = r_tx_count;
    assign rx_count     = r_rx_count;

endmodule
`default_nettype wire
